// File: rtl/tacky_fetch_decode_if.sv
// Bundle of the fetch/decode front end's external buses: instruction memory
// read port, issue handshake to execute, branch redirect, and halt status.
//   master : the fetch/decode block (drives imem request and issue fields)
//   slave  : the environment (memory, execute stage)
interface tacky_fetch_decode_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        iss_valid;
  logic        iss_ready;
  logic        iss_pair;
  logic [4:0]  iss_op_l;
  logic [4:0]  iss_op_r;
  logic [2:0]  iss_reg_l;
  logic [2:0]  iss_reg_r;
  logic [15:0] iss_lit_l;
  logic [15:0] iss_lit_r;
  logic [15:0] iss_imm;
  logic [15:0] iss_pc;
  logic [15:0] iss_next_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_data,
    output iss_valid, iss_pair, iss_op_l, iss_op_r, iss_reg_l, iss_reg_r,
           iss_lit_l, iss_lit_r, iss_imm, iss_pc, iss_next_pc,
    input  iss_ready, redirect_valid, redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr, output imem_ack, imem_data,
    input  iss_valid, iss_pair, iss_op_l, iss_op_r, iss_reg_l, iss_reg_r,
           iss_lit_l, iss_lit_r, iss_imm, iss_pc, iss_next_pc,
    output iss_ready, redirect_valid, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/tacky_fetch_decode.sv
// Tacky fetch/decode front end. Fetches 16-bit instruction words, splits
// 8-bit pairs into left/right slots, collects lf/li literal words, folds
// pre prefixes into 16-bit immediates, resolves jp8 locally and issues one
// decoded instruction at a time over a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : imem read port, issue handshake, redirect input, halted output
module tacky_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic                  clk,
  input logic                  reset,
  tacky_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_LIT_L, S_LIT_R, S_ISSUE, S_HALT
  } state_t;

  localparam logic [4:0] OP_LF  = 5'd2;
  localparam logic [4:0] OP_LI  = 5'd3;
  localparam logic [4:0] OP_PRE = 5'd17;
  localparam logic [4:0] OP_JP8 = 5'd18;
  localparam logic [4:0] OP_SYS = 5'd19;

  state_t      r_state;
  logic [15:0] r_pc, r_ir, r_lit_l, r_lit_r;
  logic [7:0]  r_pre;
  logic        r_req, r_valid, r_halted;

  logic [4:0]  w_top, w_op_r;
  logic        w_pair, w_lit_l, w_lit_r, w_stop, w_redirect, w_take;
  logic [15:0] w_next_pc, w_addr;

  // Decode of the held instruction word; only meaningful once r_ir is loaded.
  assign w_top     = r_ir[15:11];
  assign w_op_r    = r_ir[7:3];
  assign w_pair    = (w_top <= 5'd16);
  assign w_lit_l   = w_pair && (w_top == OP_LF || w_top == OP_LI);
  assign w_lit_r   = w_pair && (w_op_r == OP_LF || w_op_r == OP_LI);
  assign w_stop    = (w_top == OP_SYS) || (w_top >= 5'd24);
  assign w_next_pc = r_pc + 16'd1 + {15'd0, w_lit_l} + {15'd0, w_lit_r};
  assign w_redirect = bus.redirect_valid && (r_state != S_HALT);
  assign w_take    = r_req && bus.imem_ack;

  always_comb begin
    w_addr = r_pc;
    case (r_state)
      S_LIT_L: w_addr = r_pc + 16'd1;
      S_LIT_R: w_addr = r_pc + 16'd1 + {15'd0, w_lit_l};
      default: w_addr = r_pc;
    endcase
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = w_addr;
  assign bus.halted      = r_halted;
  assign bus.iss_valid   = r_valid;
  // Issue fields are zero whenever nothing is offered.
  assign bus.iss_pair    = r_valid && w_pair;
  assign bus.iss_op_l    = r_valid ? w_top : 5'd0;
  assign bus.iss_reg_l   = r_valid ? r_ir[10:8] : 3'd0;
  assign bus.iss_op_r    = (r_valid && w_pair) ? w_op_r : 5'd0;
  assign bus.iss_reg_r   = (r_valid && w_pair) ? r_ir[2:0] : 3'd0;
  assign bus.iss_lit_l   = (r_valid && w_lit_l) ? r_lit_l : 16'd0;
  assign bus.iss_lit_r   = (r_valid && w_lit_r) ? r_lit_r : 16'd0;
  assign bus.iss_imm     = (r_valid && !w_pair) ? {r_pre, r_ir[7:0]} : 16'd0;
  assign bus.iss_pc      = r_valid ? r_pc : 16'd0;
  assign bus.iss_next_pc = r_valid ? w_next_pc : 16'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 16'd0;
      r_lit_l  <= 16'd0;
      r_lit_r  <= 16'd0;
      r_pre    <= 8'd0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_redirect) begin
      // Drop everything in flight; req stays low for this next cycle so the
      // memory sees a clean break before the new address.
      r_pc    <= bus.redirect_pc;
      r_state <= S_FETCH;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // req is low here only right after reset or a redirect.
          if (!r_req) r_req <= 1'b1;
          else if (bus.imem_ack) begin
            r_ir    <= bus.imem_data;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_top == OP_PRE) begin
            r_pre   <= r_ir[7:0];
            r_pc    <= r_pc + 16'd1;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else if (w_top == OP_JP8) begin
            r_pc    <= {r_pre, r_ir[7:0]};
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else if (w_lit_l) begin
            r_req   <= 1'b1;
            r_state <= S_LIT_L;
          end else if (w_lit_r) begin
            r_req   <= 1'b1;
            r_state <= S_LIT_R;
          end else begin
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_LIT_L: begin
          if (w_take) begin
            r_lit_l <= bus.imem_data;
            if (w_lit_r) r_state <= S_LIT_R;  // req stays up, address moves on
            else begin
              r_req   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_LIT_R: begin
          if (w_take) begin
            r_lit_r <= bus.imem_data;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.iss_ready) begin
            r_valid <= 1'b0;
            r_pc    <= w_next_pc;
            if (w_stop) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_HALT: ;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tacky_fetch_decode.sv
// Bench for tacky_fetch_decode: directed scenarios plus random programs,
// checked against an instruction-level reference model of the decoder.
module tb_tacky_fetch_decode;

  logic clk = 1'b0;
  logic reset, reset2;
  always #5 clk = ~clk;

  tacky_fetch_decode_if bus ();
  tacky_fetch_decode_if bus2 ();

  tacky_fetch_decode #(.RESET_PC(16'h0000)) u_dut  (.clk(clk), .reset(reset),  .bus(bus));
  tacky_fetch_decode #(.RESET_PC(16'hFFFF)) u_dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  typedef struct packed {
    logic        pair;
    logic [4:0]  op_l, op_r;
    logic [2:0]  reg_l, reg_r;
    logic [15:0] lit_l, lit_r, imm, pc, next_pc;
  } iss_t;

  logic [15:0] mem [0:65535];
  iss_t        expq[$], got[$];
  logic [15:0] addrlog[$];
  int tests, fails;
  int lat_fixed, cnt, tgt;
  bit lat_rand;

  // Memory for the main DUT: ack after a fixed or random number of wait cycles.
  always @(negedge clk) begin
    if (bus.imem_req) begin
      if (cnt == 0) tgt = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      if (cnt >= tgt) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem[bus.imem_addr];
        addrlog.push_back(bus.imem_addr);
        cnt = 0;
      end else begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'd0;
        cnt++;
      end
    end else begin
      bus.imem_ack = 1'b0;
      cnt = 0;
    end
  end

  // Zero-wait memory for the second DUT.
  always @(negedge clk) begin
    bus2.imem_ack  = bus2.imem_req;
    bus2.imem_data = mem[bus2.imem_addr];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic iss_t cur();
    iss_t r;
    r.pair = bus.iss_pair;   r.op_l = bus.iss_op_l;   r.op_r = bus.iss_op_r;
    r.reg_l = bus.iss_reg_l; r.reg_r = bus.iss_reg_r;
    r.lit_l = bus.iss_lit_l; r.lit_r = bus.iss_lit_r; r.imm = bus.iss_imm;
    r.pc = bus.iss_pc;       r.next_pc = bus.iss_next_pc;
    return r;
  endfunction

  // Instruction-level interpretation of memory: what execute should receive.
  task automatic build_exp(input logic [15:0] start, input logic [7:0] pre0);
    logic [15:0] pc, w;
    logic [7:0]  pre;
    logic [4:0]  top;
    int n;
    iss_t r;
    pc = start; pre = pre0;
    for (int g = 0; g < 500; g++) begin
      w = mem[pc]; top = w[15:11];
      if (top == 5'd17) begin
        pre = w[7:0]; pc = pc + 16'd1;
      end else if (top == 5'd18) begin
        pc = {pre, w[7:0]};
      end else begin
        r = '0; r.pc = pc; r.op_l = top; r.reg_l = w[10:8]; n = 0;
        if (top <= 5'd16) begin
          r.pair = 1'b1; r.op_r = w[7:3]; r.reg_r = w[2:0];
          if (top == 5'd2 || top == 5'd3) begin r.lit_l = mem[16'(pc + 16'd1)]; n++; end
          if (w[7:3] == 5'd2 || w[7:3] == 5'd3) begin r.lit_r = mem[16'(pc + 16'(1 + n))]; n++; end
        end else r.imm = {pre, w[7:0]};
        r.next_pc = 16'(pc + 16'(1 + n));
        expq.push_back(r);
        pc = r.next_pc;
        if (top == 5'd19 || top >= 5'd24) break;
      end
    end
  endtask

  task automatic gen_prog(input logic [15:0] base);
    logic [15:0] a, t;
    logic [4:0]  opl, opr;
    int k;
    mem[0] = {5'd17, 3'd0, base[15:8]};
    mem[1] = {5'd18, 3'd0, base[7:0]};
    a = base;
    repeat ($urandom_range(8, 20)) begin
      k = int'($urandom_range(0, 9));
      if (k < 5) begin
        opl = 5'($urandom_range(0, 16)); opr = 5'($urandom_range(0, 16));
        mem[a] = {opl, 3'($urandom_range(0, 7)), opr, 3'($urandom_range(0, 7))}; a++;
        if (opl == 5'd2 || opl == 5'd3) begin mem[a] = 16'($urandom); a++; end
        if (opr == 5'd2 || opr == 5'd3) begin mem[a] = 16'($urandom); a++; end
      end else if (k < 8) begin
        mem[a] = {(k == 5) ? 5'd17 : 5'($urandom_range(20, 23)), 3'($urandom_range(0, 7)), 8'($urandom)};
        a++;
      end else begin
        t = a + 16'(2 + $urandom_range(0, 4));
        mem[a] = {5'd17, 3'd0, t[15:8]};
        mem[a + 16'd1] = {5'd18, 3'd0, t[7:0]};
        a = t;
      end
    end
    mem[a] = {($urandom_range(0, 1) == 1) ? 5'd19 : 5'($urandom_range(24, 31)),
              3'($urandom_range(0, 7)), 8'($urandom)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.iss_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'd0;
    expq.delete(); got.delete(); addrlog.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input int budget, input bit rnd_ready);
    iss_t e;
    for (int i = 0; i < budget && !bus.halted; i++) begin
      bus.iss_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.iss_valid && bus.iss_ready) begin
        got.push_back(cur());
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        chk("issue", cur(), e);
      end
      @(negedge clk);
    end
    chk("halted", bus.halted, 1);
    chk("exp_left", expq.size(), 0);
    chk("halt_noreq", bus.imem_req, 0);
  endtask

  initial begin
    iss_t e;
    tests = 0; fails = 0; cnt = 0; tgt = 0; lat_fixed = 0; lat_rand = 1'b0;
    reset = 1'b1; reset2 = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_data = 16'd0;
    bus.iss_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'd0;
    bus2.iss_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;

    // Reset state
    @(negedge clk);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.iss_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_fields", cur(), 0);

    // Plain pair, cycle timing, ready stall, then sys and halt
    mem[0] = 16'h4309; mem[1] = 16'h9800;
    do_reset();
    @(negedge clk);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 16'h0000);
    @(negedge clk);
    chk("decode_novalid", bus.iss_valid, 0);
    @(negedge clk);
    chk("plain_valid", bus.iss_valid, 1);
    e = '0; e.pair = 1'b1; e.op_l = 5'd8; e.reg_l = 3'd3; e.op_r = 5'd1; e.reg_r = 3'd1;
    e.pc = 16'd0; e.next_pc = 16'd1;
    chk("plain_fields", cur(), e);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", bus.iss_valid, 1);
      chk("stall_fields", cur(), e);
      chk("stall_noreq", bus.imem_req, 0);
    end
    bus.iss_ready = 1'b1;
    @(negedge clk);
    chk("fire_valid_drop", bus.iss_valid, 0);
    chk("next_req", bus.imem_req, 1);
    chk("next_addr", bus.imem_addr, 16'h0001);
    e = '0; e.op_l = 5'd19; e.pc = 16'd1; e.next_pc = 16'd2;
    expq.push_back(e);
    run_prog(20, 1'b0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
    repeat (3) begin
      @(negedge clk);
      chk("halt_redirect_noreq", bus.imem_req, 0);
      chk("halt_sticky", bus.halted, 1);
    end
    bus.redirect_valid = 1'b0;

    // pre + ci8, jp8 resolved locally, sys carries the prefix
    mem[0] = 16'h8812; mem[1] = 16'hAA34; mem[2] = 16'h9040; mem[16'h1240] = 16'h9800;
    do_reset();
    build_exp(16'h0000, 8'h00);
    run_prog(60, 1'b0);
    chk("pre_issue_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("ci8_op", got[0].op_l, 5'd21);
      chk("ci8_reg", got[0].reg_l, 3'd2);
      chk("ci8_imm", got[0].imm, 16'h1234);
      chk("ci8_next", got[0].next_pc, 16'd2);
      chk("sys_pc", got[1].pc, 16'h1240);
      chk("sys_imm", got[1].imm, 16'h1200);
    end

    // Both slots carry literals
    mem[0] = 16'h1912; mem[1] = 16'hBEEF; mem[2] = 16'hCAFE; mem[3] = 16'h9800;
    do_reset();
    build_exp(16'h0000, 8'h00);
    run_prog(60, 1'b0);
    if (got.size() >= 1) begin
      chk("lit_l", got[0].lit_l, 16'hBEEF);
      chk("lit_r", got[0].lit_r, 16'hCAFE);
      chk("lit_next", got[0].next_pc, 16'd3);
    end
    chk("lit_addr_count_ok", addrlog.size() >= 3, 1);
    if (addrlog.size() >= 3) begin
      chk("lit_addr0", addrlog[0], 16'd0);
      chk("lit_addr1", addrlog[1], 16'd1);
      chk("lit_addr2", addrlog[2], 16'd2);
    end

    // Redirect while collecting the left literal, slow memory
    mem[16'h0100] = 16'h4309; mem[16'h0101] = 16'h9800;
    lat_fixed = 3;
    do_reset();
    bus.iss_ready = 1'b1;
    for (int i = 0; i < 30 && !(bus.imem_req && bus.imem_addr == 16'd1); i++) @(negedge clk);
    chk("lit_l_fetch_seen", {bus.imem_req, bus.imem_addr}, {1'b1, 16'd1});
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("redir_req_drop", bus.imem_req, 0);
    chk("redir_valid", bus.iss_valid, 0);
    @(negedge clk);
    chk("redir_req", bus.imem_req, 1);
    chk("redir_addr", bus.imem_addr, 16'h0100);
    build_exp(16'h0100, 8'h00);
    run_prog(80, 1'b0);
    lat_fixed = 0;

    // Random programs, random memory latency, random ready
    lat_rand = 1'b1;
    for (int n = 0; n < 6; n++) begin
      do_reset();
      gen_prog(16'((n + 1) * 16'h1000 + int'($urandom_range(0, 255))));
      build_exp(16'h0000, 8'h00);
      run_prog(3000, 1'b1);
    end
    lat_rand = 1'b0;

    // RESET_PC = FFFF wraps, and reset during issue clears valid at once
    mem[16'hFFFF] = 16'h4309; mem[0] = 16'h4309;
    @(negedge clk);
    reset2 = 1'b0;
    for (int i = 0; i < 10 && !bus2.iss_valid; i++) @(negedge clk);
    chk("wrap_valid", bus2.iss_valid, 1);
    chk("wrap_pc", bus2.iss_pc, 16'hFFFF);
    chk("wrap_next_pc", bus2.iss_next_pc, 16'h0000);
    bus2.iss_ready = 1'b1;
    @(negedge clk);
    bus2.iss_ready = 1'b0;
    chk("wrap_fetch", {bus2.imem_req, bus2.imem_addr}, {1'b1, 16'h0000});
    for (int i = 0; i < 10 && !bus2.iss_valid; i++) @(negedge clk);
    chk("issue_before_reset", bus2.iss_valid, 1);
    #2 reset2 = 1'b1;
    #1;
    chk("async_reset_valid", bus2.iss_valid, 0);
    chk("async_reset_req", bus2.imem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
